// File: rtl/baud_tick_generator.sv
// Programmable UART baud timebase.
// Divides Clock_In by an integer+fractional divisor to make an oversample tick,
// then divides that by OVERSAMPLE to make a per-bit tick and a square bit clock.
// Restart re-phases everything to the start of a bit so RX can lock to a start edge.
module baud_tick_generator #(
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  Clock_In,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  Restart,
    input  logic                  Load,
    input  logic [DIV_WIDTH-1:0]  Divisor,
    input  logic [FRAC_WIDTH-1:0] Frac,
    output logic                  Os_Tick,
    output logic                  Baud_Tick,
    output logic                  Baud_Clk
);

    localparam int                OS_W     = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]   OS_ONE   = OS_W'(1);
    localparam logic [DIV_WIDTH:0] CNT_ONE = (DIV_WIDTH + 1)'(1);

    logic [DIV_WIDTH-1:0]  r_shadowDiv;
    logic [FRAC_WIDTH-1:0] r_shadowFrac;
    logic [DIV_WIDTH-1:0]  r_activeDiv;
    logic [FRAC_WIDTH-1:0] r_activeFrac;
    logic                  r_run;
    logic [DIV_WIDTH:0]    r_divCnt;
    logic [DIV_WIDTH:0]    r_period;
    logic [FRAC_WIDTH-1:0] r_acc;
    logic [OS_W-1:0]       r_osCnt;
    logic                  r_osTick;
    logic                  r_baudTick;
    logic                  r_baudClk;

    logic                  w_count;
    logic                  w_periodStart;
    logic [FRAC_WIDTH:0]   w_accSum;
    logic [DIV_WIDTH:0]    w_newPeriod;
    logic [DIV_WIDTH:0]    w_curPeriod;
    logic                  w_wrap;
    logic                  w_loadActive;
    logic [DIV_WIDTH-1:0]  w_nextActiveDiv;
    logic [FRAC_WIDTH-1:0] w_nextActiveFrac;

    // Counting happens only once the timebase has had one start cycle (r_run),
    // so the first tick after enable/reload/restart arrives a full period later.
    assign w_count       = Enable && !Restart && r_run && (r_activeDiv != '0);
    assign w_periodStart = w_count && (r_divCnt == '0);

    // The fractional accumulator's carry stretches the period by one cycle.
    assign w_accSum    = {1'b0, r_acc} + {1'b0, r_activeFrac};
    assign w_newPeriod = {1'b0, r_activeDiv} + {{DIV_WIDTH{1'b0}}, w_accSum[FRAC_WIDTH]};
    assign w_curPeriod = w_periodStart ? w_newPeriod : r_period;
    assign w_wrap      = w_count && (r_divCnt == (w_curPeriod - CNT_ONE));

    // Active divisor follows the shadow at period boundaries, on restart, and
    // continuously while idle; a same-cycle Load bypasses the shadow.
    assign w_loadActive     = !Enable || (r_activeDiv == '0) || w_wrap || Restart;
    assign w_nextActiveDiv  = w_loadActive ? (Load ? Divisor : r_shadowDiv)  : r_activeDiv;
    assign w_nextActiveFrac = w_loadActive ? (Load ? Frac    : r_shadowFrac) : r_activeFrac;

    // Shadow registers capture the software-programmed divisor on Load.
    always_ff @(posedge Clock_In or negedge Reset) begin
        if (!Reset) begin
            r_shadowDiv  <= '0;
            r_shadowFrac <= '0;
        end else if (Load) begin
            r_shadowDiv  <= Divisor;
            r_shadowFrac <= Frac;
        end
    end

    // Active divisor update and the start-cycle flag that gates counting.
    always_ff @(posedge Clock_In or negedge Reset) begin
        if (!Reset) begin
            r_activeDiv  <= '0;
            r_activeFrac <= '0;
            r_run        <= 1'b0;
        end else begin
            r_activeDiv  <= w_nextActiveDiv;
            r_activeFrac <= w_nextActiveFrac;
            r_run        <= Enable && (w_nextActiveDiv != '0);
        end
    end

    // Period counter, fractional accumulator and oversample position within the bit.
    always_ff @(posedge Clock_In or negedge Reset) begin
        if (!Reset) begin
            r_divCnt <= '0;
            r_period <= '0;
            r_acc    <= '0;
            r_osCnt  <= '0;
        end else if (!w_count) begin
            r_divCnt <= '0;
            r_period <= '0;
            r_acc    <= '0;
            r_osCnt  <= '0;
        end else begin
            if (w_periodStart) begin
                r_acc    <= w_accSum[FRAC_WIDTH-1:0];
                r_period <= w_newPeriod;
            end
            r_divCnt <= w_wrap ? '0 : (r_divCnt + CNT_ONE);
            if (w_wrap) begin
                r_osCnt <= (r_osCnt == OS_LAST) ? '0 : (r_osCnt + OS_ONE);
            end
        end
    end

    // Registered tick outputs and the half-bit toggling bit clock.
    always_ff @(posedge Clock_In or negedge Reset) begin
        if (!Reset) begin
            r_osTick   <= 1'b0;
            r_baudTick <= 1'b0;
            r_baudClk  <= 1'b0;
        end else if (!w_count) begin
            r_osTick   <= 1'b0;
            r_baudTick <= 1'b0;
            r_baudClk  <= 1'b0;
        end else begin
            r_osTick   <= w_wrap;
            r_baudTick <= w_wrap && (r_osCnt == OS_LAST);
            if (w_wrap && ((r_osCnt == OS_HALF) || (r_osCnt == OS_LAST))) begin
                r_baudClk <= !r_baudClk;
            end
        end
    end

    assign Os_Tick   = r_osTick;
    assign Baud_Tick = r_baudTick;
    assign Baud_Clk  = r_baudClk;

endmodule
